cla_pipelined_subtractor: RTL

//  Unsigned/two's-complement subtractor computing i_a - i_b via carry-lookahead over
//  A + ~B + 1, split into SEG_WIDTH-bit segments with one pipeline register per segment.

---
 rtl/cla_pipelined_subtractor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cla_pipelined_subtractor.sv
// Pipelined carry-lookahead subtractor: computes i_a - i_b as A + ~B + 1, resolving
// SEG_WIDTH bits per stage with a valid/ready handshake chained through every stage.
module cla_pipelined_subtractor #(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_ovf
);

  localparam int SEG_SAFE = (SEG_WIDTH < 1) ? 1 : SEG_WIDTH;
  localparam int NSEG     = WIDTH / SEG_SAFE;

  if ((SEG_WIDTH < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_param_check
    $error("cla_pipelined_subtractor: WIDTH must be a positive multiple of SEG_WIDTH");
  end

  logic [NSEG-1:0] stage_valid;
  logic [NSEG:0]   stage_ready;

  // Ready ripples back from the output; an empty stage is always ready.
  always_comb begin
    stage_ready       = '0;
    stage_ready[NSEG] = i_ready;
    for (int unsigned n = 0; n < NSEG; n++) begin
      stage_ready[NSEG-1-n] = ~stage_valid[NSEG-1-n] | stage_ready[NSEG-n];
    end
  end

  assign o_ready = stage_ready[0];

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int SRC_W  = WIDTH - k * SEG_WIDTH;
    localparam int REM_W  = SRC_W - SEG_WIDTH;
    localparam int DIFF_W = (k + 1) * SEG_WIDTH;

    logic                 in_valid;
    logic                 valid_q;
    logic                 load;
    logic [SRC_W-1:0]     src_a;
    logic [SRC_W-1:0]     src_b;
    logic                 seg_cin;
    logic [SEG_WIDTH-1:0] seg_a;
    logic [SEG_WIDTH-1:0] seg_b;
    logic [SEG_WIDTH-1:0] gen;
    logic [SEG_WIDTH-1:0] prop;
    logic [SEG_WIDTH-1:0] seg_sum;
    logic [SEG_WIDTH:0]   carry;
    logic [DIFF_W-1:0]    diff_d;
    logic [DIFF_W-1:0]    diff_q;

    if (k == 0) begin : g_src
      assign in_valid = i_valid;
      assign src_a    = i_a;
      assign src_b    = i_b;
      assign seg_cin  = 1'b1;
      assign diff_d   = seg_sum;
    end else begin : g_src
      assign in_valid = stage_valid[k-1];
      assign src_a    = g_stage[k-1].g_rem.a_rem_q;
      assign src_b    = g_stage[k-1].g_rem.b_rem_q;
      assign seg_cin  = g_stage[k-1].g_rem.carry_q;
      assign diff_d   = {seg_sum, g_stage[k-1].diff_q};
    end

    assign seg_a          = src_a[SEG_WIDTH-1:0];
    assign seg_b          = src_b[SEG_WIDTH-1:0];
    assign stage_valid[k] = valid_q;
    assign load           = stage_ready[k] & in_valid;

    // Each carry is the flattened generate/propagate prefix, not a ripple chain.
    always_comb begin
      logic acc;
      logic pchain;
      acc      = 1'b0;
      pchain   = 1'b0;
      gen      = seg_a & ~seg_b;
      prop     = seg_a | ~seg_b;
      carry    = '0;
      carry[0] = seg_cin;
      for (int unsigned i = 0; i < SEG_WIDTH; i++) begin
        acc    = gen[i];
        pchain = prop[i];
        for (int unsigned j = 1; j <= i; j++) begin
          acc    = acc | (pchain & gen[i-j]);
          pchain = pchain & prop[i-j];
        end
        carry[i+1] = acc | (pchain & seg_cin);
      end
      seg_sum = seg_a ^ ~seg_b ^ carry[SEG_WIDTH-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        valid_q <= 1'b0;
        diff_q  <= '0;
      end else if (stage_ready[k]) begin
        valid_q <= in_valid;
        if (in_valid) begin
          diff_q <= diff_d;
        end
      end
    end

    if (REM_W > 0) begin : g_rem
      logic [REM_W-1:0] a_rem_q;
      logic [REM_W-1:0] b_rem_q;
      logic             carry_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
          carry_q <= 1'b0;
        end else if (load) begin
          a_rem_q <= src_a[SRC_W-1:SEG_WIDTH];
          b_rem_q <= src_b[SRC_W-1:SEG_WIDTH];
          carry_q <= carry[SEG_WIDTH];
        end
      end
    end else begin : g_last
      logic borrow_q;
      logic ovf_q;

      // The final segment still holds the operand MSBs, so flags are registered here.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          borrow_q <= 1'b0;
          ovf_q    <= 1'b0;
        end else if (load) begin
          borrow_q <= ~carry[SEG_WIDTH];
          ovf_q    <= (seg_a[SEG_WIDTH-1] ^ seg_b[SEG_WIDTH-1]) &
                      (seg_sum[SEG_WIDTH-1] ^ seg_a[SEG_WIDTH-1]);
        end
      end
    end
  end

  assign o_valid  = stage_valid[NSEG-1];
  assign o_diff   = g_stage[NSEG-1].diff_q;
  assign o_borrow = g_stage[NSEG-1].g_last.borrow_q;
  assign o_ovf    = g_stage[NSEG-1].g_last.ovf_q;

endmodule
